// File: rtl/ce_cadence_monitor.sv
// Receive-side cadence checker for the 24 MHz clock-enable bundle; locks onto ce1m5 and flags deviations.
// Optional pipe_ab half-period check enabled by defining CE_CADENCE_PIPEAB_CHECK_EN.
module ce_cadence_monitor #(
  parameter int LOCK_PERIODS = 4,
  parameter int ERR_W        = 8
) (
  input  logic             clk24,
  input  logic             reset,
  input  logic             ce12,
  input  logic             ce6,
  input  logic             ce3,
  input  logic             ce3v,
  input  logic             video_slice,
  input  logic             ce1m5,
  input  logic             pipe_ab,
  output logic             locked,
  output logic             fault,
  output logic [5:0]       err_mask,
  output logic [ERR_W-1:0] err_count,
  output logic [3:0]       phase
);

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } state_t;

  localparam logic [3:0]       LOCK_TARGET = 4'(LOCK_PERIODS);
  localparam logic [ERR_W-1:0] ERR_ONE     = {{(ERR_W-1){1'b0}}, 1'b1};
  localparam logic [ERR_W-1:0] ERR_MAX     = {ERR_W{1'b1}};

  state_t     state;
  logic [3:0] period_cnt;

  // Only the low three bits of (phase + 13) feed the prediction; 13 mod 8 = 5.
  logic [2:0] c;
  assign c = phase[2:0] + 3'd5;

  logic [4:0] expected;
  logic [4:0] observed;
  logic [4:0] mm_strobe;
  logic       mm_ref;
  logic       mm_pab;
  logic       pab_ok;
  logic [5:0] mm;
  logic       any_mm;

  assign expected  = {~c[2], c[2] & c[1] & ~c[0], c[2] & ~c[1] & c[0], c[1] & c[0], c[0]};
  assign observed  = {video_slice, ce3v, ce3, ce6, ce12};
  assign mm_strobe = expected ^ observed;
  assign mm_ref    = ce1m5 ^ (phase == 4'd0);
  assign mm        = {mm_pab, mm_strobe};
  assign any_mm    = (|mm) | mm_ref;

`ifdef CE_CADENCE_PIPEAB_CHECK_EN
  logic pab_prev;
  logic pab_aligned;
  logic pab_half;
  logic pab_edge;
  logic pab_slot;

  assign pab_edge = pipe_ab ^ pab_prev;
  assign pab_slot = (phase == 4'd3);
  assign pab_ok   = pab_aligned;

  // Edges are legal only in the phase-3 slot; once aligned, every second slot must carry one.
  always_comb begin
    mm_pab = 1'b0;
    if (state != HUNT) begin
      if (pab_edge && !pab_slot)
        mm_pab = 1'b1;
      else if (pab_slot && pab_aligned && (pab_edge != pab_half))
        mm_pab = 1'b1;
    end
  end

  always_ff @(posedge clk24 or posedge reset) begin
    if (reset) begin
      pab_prev    <= 1'b0;
      pab_aligned <= 1'b0;
      pab_half    <= 1'b0;
    end else begin
      pab_prev <= pipe_ab;
      if (state == HUNT || any_mm) begin
        pab_aligned <= 1'b0;
        pab_half    <= 1'b0;
      end else if (pab_slot) begin
        if (!pab_aligned) begin
          if (pab_edge) begin
            pab_aligned <= 1'b1;
            pab_half    <= 1'b0;
          end
        end else begin
          pab_half <= ~pab_half;
        end
      end
    end
  end
`else
  logic unused_pipe_ab;
  assign unused_pipe_ab = pipe_ab;
  assign mm_pab         = 1'b0;
  assign pab_ok         = 1'b1;
`endif

  always_ff @(posedge clk24 or posedge reset) begin
    if (reset) begin
      state      <= HUNT;
      phase      <= 4'd0;
      period_cnt <= 4'd0;
      locked     <= 1'b0;
      fault      <= 1'b0;
      err_mask   <= 6'd0;
      err_count  <= '0;
    end else begin
      fault <= 1'b0;
      phase <= phase + 4'd1;
      case (state)
        HUNT: begin
          locked <= 1'b0;
          if (ce1m5) begin
            // The ce1m5 cycle is phase 0, so the next one is phase 1.
            phase      <= 4'd1;
            period_cnt <= 4'd0;
            state      <= VERIFY;
          end
        end
        VERIFY: begin
          locked <= 1'b0;
          if (any_mm) begin
            period_cnt <= 4'd0;
            state      <= HUNT;
          end else if (period_cnt == LOCK_TARGET && pab_ok) begin
            state <= LOCKED;
          end else if (phase == 4'd15 && period_cnt != LOCK_TARGET) begin
            period_cnt <= period_cnt + 4'd1;
          end
        end
        LOCKED: begin
          if (any_mm) begin
            fault    <= 1'b1;
            err_mask <= err_mask | mm;
            if (err_count != ERR_MAX)
              err_count <= err_count + ERR_ONE;
            locked     <= 1'b0;
            period_cnt <= 4'd0;
            state      <= HUNT;
          end else begin
            locked <= 1'b1;
          end
        end
        default: begin
          locked <= 1'b0;
          state  <= HUNT;
        end
      endcase
    end
  end

endmodule
